// File: rtl/timer_apb_regif.sv
`default_nettype none
// ============================================================================
//  Module      : timer_apb_regif
//  Description : APB responder register block for the 8-bit timer. Decodes
//                paddr, holds TDR / TCR / TSR, feeds configuration to the
//                counter core and returns register contents on reads.
//                A registered pready is produced after WAIT_CYCLES wait
//                states in the access phase.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Build option:
//    TIMER_APB_PSLVERR_EN - when defined, accesses to unmapped addresses and
//                           writes to TCNT complete with pslverr=1, change no
//                           register and return prdata=0. When undefined,
//                           pslverr is tied low and such accesses are ignored.
// ----------------------------------------------------------------------------
//  Parameters:
//    WAIT_CYCLES : access-phase cycles with pready=0 before pready=1 (0..7)
//    TCR_MASK    : writable bits of TCR; masked bits always read 0
// ----------------------------------------------------------------------------
//  Ports:
//    pclk, presetn        : clock, asynchronous active-low reset
//    psel, penable,
//    pwrite, paddr,
//    pwdata               : APB request from the CPU-side master
//    prdata, pready,
//    pslverr              : APB response (all registered)
//    cnt_in               : live counter value, readable as TCNT
//    ovf_set, udf_set     : one-cycle status set pulses from the core
//    tdr, tcr, tsr        : register contents driven to the core
// ----------------------------------------------------------------------------
//  Address map:
//    8'h00 TDR  RW
//    8'h01 TCR  RW (masked by TCR_MASK, bit 7 self-clears)
//    8'h02 TSR  R {6'b0,tsr}, W1C per bit
//    8'h03 TCNT RO (cnt_in)
// ============================================================================
module timer_apb_regif #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [7:0]  TCR_MASK    = 8'hB3
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic [7:0] cnt_in,
    input  logic       ovf_set,
    input  logic       udf_set,
    output logic [7:0] tdr,
    output logic [7:0] tcr,
    output logic [1:0] tsr
);

    localparam logic [7:0] c_ADDR_TDR  = 8'h00;
    localparam logic [7:0] c_ADDR_TCR  = 8'h01;
    localparam logic [7:0] c_ADDR_TSR  = 8'h02;
    localparam logic [7:0] c_ADDR_TCNT = 8'h03;

    localparam logic [2:0] c_WAIT_LOAD = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [7:0] tdr_q,   tdr_d;
    logic [7:0] tcr_q,   tcr_d;
    logic [1:0] tsr_q,   tsr_d;
    logic [7:0] prdata_q, prdata_d;
    logic       pready_q;
    logic       pslverr_q;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic w_sel_tdr;
    logic w_sel_tcr;
    logic w_sel_tsr;
    logic w_sel_tcnt;
    logic w_mapped;
    logic w_err;

    assign w_sel_tdr  = (paddr == c_ADDR_TDR);
    assign w_sel_tcr  = (paddr == c_ADDR_TCR);
    assign w_sel_tsr  = (paddr == c_ADDR_TSR);
    assign w_sel_tcnt = (paddr == c_ADDR_TCNT);
    assign w_mapped   = w_sel_tdr | w_sel_tcr | w_sel_tsr | w_sel_tcnt;

`ifdef TIMER_APB_PSLVERR_EN
    // Unmapped accesses and TCNT writes are reported as errors.
    assign w_err = ~w_mapped | (pwrite & w_sel_tcnt);
`else
    // No error reporting: pslverr_q can never be set.
    assign w_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Transfer FSM: next state and wait counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Setup phase starts a transfer.
                if (psel && !penable) begin
                    if (c_WAIT_LOAD == 3'd0) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = c_WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    // Master abandoned the transfer: nothing is committed.
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else if (penable) begin
                    if (cnt_q == 3'd1) begin
                        state_d = ST_READY;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read data: captured on the edge that enters READY so that prdata
    // is valid for exactly the cycle in which pready is high.
    // ------------------------------------------------------------------
    always_comb begin
        prdata_d = 8'h00;
        if ((state_d == ST_READY) && !pwrite && !w_err) begin
            case (paddr)
                c_ADDR_TDR:  prdata_d = tdr_q;
                c_ADDR_TCR:  prdata_d = tcr_q;
                c_ADDR_TSR:  prdata_d = {6'b000000, tsr_q};
                c_ADDR_TCNT: prdata_d = cnt_in;
                default:     prdata_d = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register updates. Writes commit on the edge that ends READY.
    // ------------------------------------------------------------------
    logic       w_wr_en;
    logic [1:0] w_w1c;

    assign w_wr_en = (state_q == ST_READY) & psel & penable & pwrite & ~w_err;
    assign w_w1c   = (w_wr_en && w_sel_tsr) ? pwdata[1:0] : 2'b00;

    always_comb begin
        tdr_d = tdr_q;
        if (w_wr_en && w_sel_tdr) begin
            tdr_d = pwdata;
        end
    end

    always_comb begin
        tcr_d    = tcr_q;
        // Load strobe lasts a single cycle after being written.
        tcr_d[7] = 1'b0;
        if (w_wr_en && w_sel_tcr) begin
            tcr_d = pwdata & TCR_MASK;
        end
    end

    // Hardware set takes priority over a simultaneous software clear.
    assign tsr_d = (tsr_q & ~w_w1c) | {udf_set, ovf_set};

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            tdr_q     <= 8'h00;
            tcr_q     <= 8'h00;
            tsr_q     <= 2'b00;
            prdata_q  <= 8'h00;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tdr_q     <= tdr_d;
            tcr_q     <= tcr_d;
            tsr_q     <= tsr_d;
            prdata_q  <= prdata_d;
            pready_q  <= (state_d == ST_READY);
            pslverr_q <= (state_d == ST_READY) & w_err;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign tdr     = tdr_q;
    assign tcr     = tcr_q;
    assign tsr     = tsr_q;

endmodule
`default_nettype wire

// File: doc/timer_apb_regif.md
Name: timer_apb_regif

Overview:
- APB slave (responder) register interface for the 8-bit timer; the other end of the CPU-side APB master that issues write and read transfers.
- Decodes paddr and holds TDR, TCR and TSR.
- Drives configuration outputs to the timer counter core and returns register contents on reads.
- Inserts a configurable number of wait states through a registered pready.

Parameters:
- WAIT_CYCLES, 1, number of access-phase cycles with pready=0 before pready=1 (0..7).
- TCR_MASK, 8'hB3, writable bit mask for TCR; masked bits always read 0.

Ports:
- pclk  input  1  APB clock; single clock domain.
- presetn  input  1  asynchronous active-low reset.
- psel  input  1  slave select.
- penable  input  1  access phase.
- pwrite  input  1  1=write, 0=read.
- paddr  input  8  byte address.
- pwdata  input  8  write data.
- prdata  output  8  read data, registered.
- pready  output  1  transfer complete, registered.
- pslverr  output  1  error response (see Optional Feature).
- cnt_in  input  8  live counter value from core, readable as TCNT.
- ovf_set  input  1  one-cycle overflow pulse from core.
- udf_set  input  1  one-cycle underflow pulse from core.
- tdr  output  8  reload value to core.
- tcr  output  8  control: [7] load, [5] up/down, [4] enable, [1:0] clock select.
- tsr  output  2  status: [0] ovf, [1] udf.

Behaviour:
- Clock and reset: one clock, pclk; reset is asynchronous, active-low, presetn.
- Reset values: prdata=0, pready=0, pslverr=0, tdr=8'h00, tcr=8'h00, tsr=2'b00, FSM=IDLE, wait counter=0.
- Address map; other addresses are unmapped:
  - 8'h00 TDR, RW.
  - 8'h01 TCR, RW, masked by TCR_MASK.
  - 8'h02 TSR, read {6'b0,tsr}; write-1-to-clear per bit.
  - 8'h03 TCNT, read-only cnt_in, sampled in READY.
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - psel=1 and penable=0 (setup phase) with WAIT_CYCLES=0 -> READY.
  - Same condition with WAIT_CYCLES>0 -> WAIT, counter loaded with WAIT_CYCLES.
- WAIT:
  - Counter decrements each cycle with psel&penable.
  - At counter==1 -> READY.
  - psel=0 -> IDLE; abort, no register update.
- READY:
  - pready=1 for exactly one cycle.
  - Read: prdata driven with the register value in the same cycle.
  - Write: register updated on the clock edge ending READY when psel&penable&pwrite.
  - Next state IDLE; pready and prdata return to 0.
- Latency: pready is high in access cycle WAIT_CYCLES+1, so a transfer is WAIT_CYCLES+2 pclk cycles including setup.
- Back-to-back: a new setup phase in the cycle after READY is accepted normally.
- Write data:
  - Written bits outside TCR_MASK are dropped.
  - Writes to TCNT have no effect.
- Read-back: data written to TDR reads back identically on any subsequent read of 8'h00.
- tcr[7] (load):
  - Self-clearing one cycle after being written 1.
  - Reads return the current bit; the written 1 is therefore visible only if read within that cycle.
- TSR status bits:
  - Each bit is set by its set pulse.
  - Simultaneous hardware set and software W1C on the same bit: set wins.
  - Set pulses during reset are ignored.
- Reset mid-transfer:
  - Immediate return to reset values.
  - The master sees pready=0; no partial write occurs.
- pslverr is only meaningful while pready=1.

Optional Feature:
- Macro: TIMER_APB_PSLVERR_EN.
- When defined: pslverr=1 together with pready=1 for accesses to unmapped addresses and for writes to TCNT.
  - No register changes on an erroring access.
  - prdata=0 on an erroring read.
- When not defined:
  - pslverr is constant 0.
  - Unmapped reads return 8'h00; unmapped and TCNT writes are silently ignored.

Test Plan:
- Reset: drive presetn=0 then release -> all outputs 0 and a read of 8'h00 returns 8'h00.
- TDR write/read: 20 random values written to 8'h00 then read -> each rdata equals wdata; pready high exactly in access cycle 2 (WAIT_CYCLES=1).
- TCR mask: write 8'hFF to 8'h01 -> read returns 8'h33; tcr[7] pulses one cycle then 0.
- TSR: pulse ovf_set -> read 8'h02 = 8'h01.
  - Write 8'h01 in the same cycle as a new ovf_set -> tsr[0] stays 1.
  - A later write of 8'h01 clears it; read returns 8'h00.
- Abort/reset: deassert psel during WAIT, or pulse presetn=0 mid-write of 8'hA5 to TDR -> TDR unchanged (8'h00), pready never asserted.
- TIMER_APB_PSLVERR_EN: read 8'h10 and write 8'h5A to 8'h03.
  - With the macro: pslverr=1 with pready, prdata=0.
  - Without the macro: pslverr=0, read returns 8'h00.
